// File: rtl/mysys_ram_pixel_writer.sv
// Packs an 8-bit pixel stream into 32-bit little-endian words and writes them to an
// on-chip RAM over Avalon-MM. Optional macro RAM_WRITER_PARTIAL_FLUSH_EN writes a trailing partial word.
module mysys_ram_pixel_writer #(
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sop,
    input  logic        pix_eop,
    output logic        pix_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [12:0] word_count,
    output logic [11:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    output logic        avm_chipselect,
    output logic        avm_write
);

    localparam logic [11:0] BASE12    = 12'(BASE_ADDR);
    localparam logic [12:0] FRAME_LIM = 13'(FRAME_WORDS);

    typedef enum logic [2:0] {IDLE, WAIT_SOP, PACK, FLUSH, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pack_q;
    logic [1:0]  byte_idx;

    logic        accept, restart, in_beat, start_ok;
    logic [1:0]  lane;
    logic [31:0] merged, wr_mask;
    logic [12:0] wc_base;
    logic        full_word, part_word, want_wr, room, wr_d;
    logic [3:0]  be_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = WAIT_SOP;
            end
            WAIT_SOP: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_sop) state_d = pix_eop ? FLUSH : PACK;
            end
            PACK: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_eop) state_d = FLUSH;
            end
            FLUSH: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A sop beat always restarts the frame: it lands in lane 0 of a fresh word
    // and the word counter starts over from zero.
    always_comb begin
        accept   = pix_valid && pix_ready;
        start_ok = start && (state_q == IDLE);
        restart  = accept && pix_sop;
        in_beat  = restart || (accept && state_q == PACK);
        lane     = restart ? 2'd0 : byte_idx;
        wc_base  = restart ? 13'd0 : word_count;
        merged   = restart ? 32'd0 : pack_q;
        merged[{lane, 3'b000} +: 8] = pix_data;

        full_word = in_beat && (lane == 2'd3);
`ifdef RAM_WRITER_PARTIAL_FLUSH_EN
        part_word = in_beat && pix_eop && (lane != 2'd3);
`else
        part_word = 1'b0;
`endif
        be_d = 4'hF;
        if (!full_word) begin
            case (lane)
                2'd0:    be_d = 4'h1;
                2'd1:    be_d = 4'h3;
                default: be_d = 4'h7;
            endcase
        end
        want_wr = full_word || part_word;
        room    = wc_base < FRAME_LIM;
        wr_d    = want_wr && room;
        wr_mask = {{8{be_d[3]}}, {8{be_d[2]}}, {8{be_d[1]}}, {8{be_d[0]}}};
    end

    // Bus signals are registered so a word completed at edge N is on the bus for cycle N+1 only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            avm_byteenable <= 4'h0;
            avm_writedata  <= 32'd0;
            avm_address    <= 12'd0;
            word_count     <= 13'd0;
            pack_q         <= 32'd0;
            byte_idx       <= 2'd0;
            overflow       <= 1'b0;
        end else begin
            avm_write      <= wr_d;
            avm_chipselect <= wr_d;
            avm_byteenable <= wr_d ? be_d : 4'h0;
            avm_writedata  <= wr_d ? (merged & wr_mask) : 32'd0;
            avm_address    <= wr_d ? (BASE12 + wc_base[11:0]) : 12'd0;

            if (start_ok)     word_count <= 13'd0;
            else if (in_beat) word_count <= wc_base + {12'd0, wr_d};

            if (in_beat) begin
                pack_q   <= merged;
                byte_idx <= pix_eop ? 2'd0 : 2'(lane + 2'd1);
            end

            if (start_ok)                overflow <= 1'b0;
            else if (want_wr && !room)   overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mysys_ram_pixel_writer.sv
// Directed bench: instance a (BASE 0x100, 4096 words) and instance b (BASE 4095, 2 words)
// share one stimulus stream; bus writes of each are logged and compared with hand-computed words.
module tb_mysys_ram_pixel_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0;

    logic        a_ready, a_busy, a_done, a_ovf, a_cs, a_wr;
    logic [12:0] a_wc;
    logic [11:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_data;
    logic        b_ready, b_busy, b_done, b_ovf, b_cs, b_wr;
    logic [12:0] b_wc;
    logic [11:0] b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_data;

    int vectors = 0;
    int miscompares = 0;
    int bad_idle = 0;
    logic [48:0] qa[$];
    logic [48:0] qb[$];

    always #5 clk = ~clk;

    mysys_ram_pixel_writer #(.BASE_ADDR(32'h100), .FRAME_WORDS(4096)) u_a (
        .clk(clk), .reset(reset), .start(start), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop),
        .pix_ready(a_ready), .busy(a_busy), .done(a_done), .overflow(a_ovf),
        .word_count(a_wc), .avm_address(a_addr), .avm_byteenable(a_be),
        .avm_writedata(a_data), .avm_chipselect(a_cs), .avm_write(a_wr));

    mysys_ram_pixel_writer #(.BASE_ADDR(4095), .FRAME_WORDS(2)) u_b (
        .clk(clk), .reset(reset), .start(start), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_sop(pix_sop), .pix_eop(pix_eop),
        .pix_ready(b_ready), .busy(b_busy), .done(b_done), .overflow(b_ovf),
        .word_count(b_wc), .avm_address(b_addr), .avm_byteenable(b_be),
        .avm_writedata(b_data), .avm_chipselect(b_cs), .avm_write(b_wr));

    // Log every bus cycle mid-period; an idle bus must show all-zero strobes.
    always @(negedge clk) begin
        if (a_wr) qa.push_back({a_cs, a_addr, a_be, a_data});
        else if (a_cs || a_be != 4'h0) bad_idle++;
        if (b_wr) qb.push_back({b_cs, b_addr, b_be, b_data});
        else if (b_cs || b_be != 4'h0) bad_idle++;
    end

    function automatic logic [48:0] wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        return {1'b1, a, be, d};
    endfunction

    function automatic logic [48:0] qget(input logic [48:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 49'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic s, input logic e);
        pix_data = d; pix_sop = s; pix_eop = e; pix_valid = 1'b1;
        tick(1);
        pix_valid = 1'b0; pix_sop = 1'b0; pix_eop = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd0);
        chk("rst_wc", 64'(a_wc), 64'd0);
        chk("rst_ovf", 64'(a_ovf), 64'd0);
        chk("rst_done", 64'(a_done), 64'd0);
        chk("rst_wr", 64'({a_wr, a_cs, a_be, a_addr, a_data}), 64'd0);
        reset = 1'b0;
        tick(2);
        chk("post_rst_nowrite", 64'(qa.size() + qb.size()), 64'd0);

        // 8-byte frame: two full words, write one cycle after 4th byte
        do_start();
        chk("armed_ready", 64'(a_ready), 64'd1);
        beat(8'h01, 1'b1, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        beat(8'h04, 1'b0, 1'b0);
        chk("wr_cycle_n1", 64'({a_wr, a_be, a_data}), 64'({1'b1, 4'hF, 32'h04030201}));
        beat(8'h05, 1'b0, 1'b0);
        chk("wr_one_cycle", 64'(a_wr), 64'd0);
        beat(8'h06, 1'b0, 1'b0);
        beat(8'h07, 1'b0, 1'b0);
        beat(8'h08, 1'b0, 1'b1);
        chk("flush_state", 64'({a_busy, a_ready, a_done}), 64'({1'b1, 1'b0, 1'b0}));
        tick(1);
        chk("done_pulse", 64'({a_busy, a_done}), 64'({1'b1, 1'b1}));
        tick(1);
        chk("back_idle", 64'({a_busy, a_done}), 64'd0);
        chk("f1_a_nwr", 64'(qa.size()), 64'd2);
        chk("f1_a_w0", 64'(qget(qa, 0)), 64'(wr(12'h100, 4'hF, 32'h04030201)));
        chk("f1_a_w1", 64'(qget(qa, 1)), 64'(wr(12'h101, 4'hF, 32'h08070605)));
        chk("f1_a_wc", 64'(a_wc), 64'd2);
        chk("f1_b_w0", 64'(qget(qb, 0)), 64'(wr(12'hFFF, 4'hF, 32'h04030201)));
        chk("f1_b_wrap", 64'(qget(qb, 1)), 64'(wr(12'h000, 4'hF, 32'h08070605)));
        chk("f1_b_ovf", 64'(b_ovf), 64'd0);
        qa.delete(); qb.delete();

        // 12-byte frame: b limited to 2 words -> overflow
        do_start();
        for (int i = 0; i < 12; i++)
            beat(8'h61 + 8'(i), i == 0, i == 11);
        tick(3);
        chk("f2_a_nwr", 64'(qa.size()), 64'd3);
        chk("f2_a_w2", 64'(qget(qa, 2)), 64'(wr(12'h102, 4'hF, 32'h6C6B6A69)));
        chk("f2_a_ovf", 64'(a_ovf), 64'd0);
        chk("f2_b_nwr", 64'(qb.size()), 64'd2);
        chk("f2_b_wc", 64'(b_wc), 64'd2);
        chk("f2_b_ovf_sticky", 64'(b_ovf), 64'd1);
        tick(2);
        chk("f2_b_ovf_idle", 64'(b_ovf), 64'd1);
        qa.delete(); qb.delete();

        // 6-byte frame: trailing partial word
        do_start();
        chk("ovf_clr_start", 64'(b_ovf), 64'd0);
        for (int i = 0; i < 6; i++)
            beat(8'h11 + 8'(i), i == 0, i == 5);
        tick(3);
        chk("f3_a_w0", 64'(qget(qa, 0)), 64'(wr(12'h100, 4'hF, 32'h14131211)));
`ifdef RAM_WRITER_PARTIAL_FLUSH_EN
        chk("f3_a_nwr", 64'(qa.size()), 64'd2);
        chk("f3_a_part", 64'(qget(qa, 1)), 64'(wr(12'h101, 4'h3, 32'h00001615)));
        chk("f3_a_wc", 64'(a_wc), 64'd2);
        chk("f3_b_part", 64'(qget(qb, 1)), 64'(wr(12'h000, 4'h3, 32'h00001615)));
`else
        chk("f3_a_nwr", 64'(qa.size()), 64'd1);
        chk("f3_a_wc", 64'(a_wc), 64'd1);
        chk("f3_b_nwr", 64'(qb.size()), 64'd1);
`endif
        qa.delete(); qb.delete();

        // reset mid-frame after 2 bytes, then a clean 4-byte frame
        do_start();
        beat(8'h21, 1'b1, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        chk("pre_rst_busy", 64'(a_busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", 64'({a_busy, a_ready, a_done, a_ovf, a_wc, a_wr}), 64'd0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_nowrite", 64'(qa.size()), 64'd0);
        do_start();
        beat(8'h31, 1'b1, 1'b0);
        beat(8'h32, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 1'b0);
        beat(8'h34, 1'b0, 1'b1);
        tick(3);
        chk("f4_a_nwr", 64'(qa.size()), 64'd1);
        chk("f4_a_w0", 64'(qget(qa, 0)), 64'(wr(12'h100, 4'hF, 32'h34333231)));
        chk("f4_a_wc", 64'(a_wc), 64'd1);
        qa.delete(); qb.delete();

        // stray non-sop beat discarded; sop re-asserted after 3 bytes restarts frame
        do_start();
        beat(8'h99, 1'b0, 1'b0);
        beat(8'h41, 1'b1, 1'b0);
        beat(8'h42, 1'b0, 1'b0);
        beat(8'h43, 1'b0, 1'b0);
        beat(8'h51, 1'b1, 1'b0);
        beat(8'h52, 1'b0, 1'b0);
        beat(8'h53, 1'b0, 1'b0);
        beat(8'h54, 1'b0, 1'b1);
        tick(3);
        chk("f5_a_nwr", 64'(qa.size()), 64'd1);
        chk("f5_a_w0", 64'(qget(qa, 0)), 64'(wr(12'h100, 4'hF, 32'h54535251)));
        chk("f5_b_w0", 64'(qget(qb, 0)), 64'(wr(12'hFFF, 4'hF, 32'h54535251)));
        chk("f5_a_wc", 64'(a_wc), 64'd1);

        chk("idle_bus_zero", 64'(bad_idle), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mysys_ram_pixel_writer.md
MYSYS_RAM_PIXEL_WRITER -- requirements
Module: mysys_ram_pixel_writer

Interface
REQ-001 Parameter BASE_ADDR, default 0, SHALL be the 12-bit word address of the first frame word.
REQ-002 Parameter FRAME_WORDS, default 4096, range 1..4096, SHALL be the maximum words written per frame.
REQ-003 Port clk, input, 1, SHALL be the single clock for all logic.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port start, input, 1, SHALL arm capture of one frame.
REQ-006 Port pix_data, input, 8, SHALL carry one pixel byte.
REQ-007 Ports pix_valid, pix_sop and pix_eop, inputs, 1 each, SHALL be the beat valid, start-of-frame and end-of-frame flags.
REQ-008 Port pix_ready, output, 1, SHALL indicate that a beat is accepted when pix_valid is also high.
REQ-009 Ports busy, done and overflow, outputs, 1 each, SHALL be the frame-active level, the one-cycle completion pulse and the sticky overflow flag.
REQ-010 Port word_count, output, 13, SHALL be the number of words written in the current frame.
REQ-011 Ports avm_address (12), avm_byteenable (4), avm_writedata (32), avm_chipselect (1) and avm_write (1), outputs, SHALL form the Avalon-MM write master to the on-chip RAM slave, which has no waitrequest.

Function
REQ-012 The FSM SHALL have the states IDLE, WAIT_SOP, PACK, FLUSH and DONE.
REQ-013 IDLE SHALL move to WAIT_SOP on start=1; start outside IDLE SHALL be ignored.
REQ-014 WAIT_SOP: pix_ready=1; beats without pix_sop are discarded; an accepted sop beat is byte 0 and the FSM enters PACK.
REQ-015 PACK: pix_ready=1; an accepted byte SHALL go to lane byte_idx[1:0], little-endian with byte 0 in bits 7:0.
REQ-016 Acceptance of the 4th byte at edge N SHALL drive avm_write=avm_chipselect=1 and avm_byteenable=4'hF for exactly cycle N+1, without stalling input.
REQ-017 avm_address SHALL be (BASE_ADDR + word_count) mod 4096 and wrap from 4095 to 0; word_count SHALL increment after each write.
REQ-018 Once word_count=FRAME_WORDS, further words SHALL be dropped with no bus write, overflow SHALL be set, and acceptance SHALL continue until eop.
REQ-019 An accepted pix_sop while in PACK SHALL discard the partial word, clear word_count, and start a new frame with that beat as byte 0.
REQ-020 Acceptance of an eop beat at edge N SHALL enter FLUSH for cycle N+1, issuing any pending write there; DONE follows with done=1 for cycle N+2; IDLE follows at N+3.
REQ-021 In IDLE, FLUSH and DONE, pix_ready SHALL be 0; busy SHALL be 1 in every state except IDLE.
REQ-022 When no write is issued, avm_write and avm_chipselect SHALL be 0 and avm_byteenable SHALL be 0.
REQ-023 overflow SHALL clear only on reset or on start accepted in IDLE.

Reset
REQ-024 Asserting reset SHALL immediately force IDLE, abort any frame, and clear the partial word.
REQ-025 During reset, all outputs SHALL be 0, including word_count and overflow.
REQ-026 No bus write SHALL be issued in the cycle following reset deassertion.

Configuration
REQ-027 With RAM_WRITER_PARTIAL_FLUSH_EN defined, a partial word (1-3 bytes) at eop SHALL be written in FLUSH with byteenable of the filled lanes only (1 byte=4'h1, 2=4'h3, 3=4'h7), unused lanes 0, and word_count incremented.
REQ-028 Without RAM_WRITER_PARTIAL_FLUSH_EN, a partial word at eop SHALL be discarded with no write and no word_count change.

Verification
REQ-029 BASE_ADDR=0x100; start; 8 bytes 0x01..0x08 with sop on the first and eop on the last -> writes 0x04030201@0x100 and 0x08070605@0x101, both BE=F; done one cycle after FLUSH; word_count=2.
REQ-030 FRAME_WORDS=2; 12 bytes -> exactly 2 writes; overflow=1 until the next start.
REQ-031 6-byte frame -> with the macro, 2nd write BE=4'h3 and data[15:0]=bytes 5,6; without it, one write only and word_count=1.
REQ-032 BASE_ADDR=4095; 8 bytes -> writes at 4095 then 0.
REQ-033 Reset asserted mid-PACK after 2 bytes -> outputs 0 immediately; a new start plus a 4-byte frame yields one write at BASE_ADDR.
REQ-034 sop re-asserted after 3 bytes, then 4 more bytes -> only the latter 4 are written, at BASE_ADDR.
